// File: rtl/and_or_self_test.sv
// Built-in self-test sequencer for the gate out = (in1 & in2) | in3: walks all 8 input vectors,
// compares the sampled gate output against the expected value. Optional macro: AND_OR_FAULT_INJECT_EN.
module and_or_self_test #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       injectFault,
    output logic       in1Drv,
    output logic       in2Drv,
    output logic       in3Drv,
    input  logic       dutOut,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] errCount,
    output logic [7:0] failVector
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] err_q, err_d;
    logic [7:0] fail_q, fail_d;
    logic       busy_q, done_q, pass_q;
    logic       obs_s;
    logic       exp_s;

`ifdef AND_OR_FAULT_INJECT_EN
    assign obs_s = dutOut ^ injectFault;
`else
    logic unused_inject_s;
    assign unused_inject_s = injectFault;
    assign obs_s           = dutOut;
`endif

    assign exp_s = (idx_q[2] & idx_q[1]) | idx_q[0];

    // Next-state and result-update logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fail_d  = fail_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_SETTLE;
                    idx_d   = 3'd0;
                    cnt_d   = 8'd0;
                    err_d   = 4'd0;
                    fail_d  = 8'd0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_SAMPLE: begin
                if (obs_s != exp_s) begin
                    fail_d = fail_q | (8'd1 << idx_q);
                    err_d  = err_q + 4'd1;
                end else begin
                    fail_d = fail_q;
                end
                // The last vector stays on the drivers while results are held.
                if (idx_q == 3'd7) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    cnt_d   = 8'd0;
                    state_d = ST_SETTLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, index, counter, results and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= 8'd0;
            err_q   <= 4'd0;
            fail_q  <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            busy_q  <= (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
            done_q  <= (state_d == ST_DONE);
            pass_q  <= (state_d == ST_DONE) && (err_d == 4'd0);
        end
    end

    assign in1Drv     = idx_q[2];
    assign in2Drv     = idx_q[1];
    assign in3Drv     = idx_q[0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign errCount   = err_q;
    assign failVector = fail_q;

endmodule

// File: tb/tb_and_or_self_test.sv
// Directed self-checking bench for and_or_self_test with a switchable gate model
// (good, stuck-at-0, stuck-at-1).
module tb_and_or_self_test;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       inject = 1'b0;
    logic       in1_drv, in2_drv, in3_drv;
    logic       dut_out;
    logic       busy, done, pass;
    logic [3:0] err_count;
    logic [7:0] fail_vector;
    int         gate_mode = 0;
    int         total = 0;
    int         bad = 0;

    and_or_self_test #(.SETTLE_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .injectFault(inject),
        .in1Drv     (in1_drv),
        .in2Drv     (in2_drv),
        .in3Drv     (in3_drv),
        .dutOut     (dut_out),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .errCount   (err_count),
        .failVector (fail_vector)
    );

    always #5 clk = ~clk;

    // Gate model: 0 = good gate, 1 = stuck at 0, 2 = stuck at 1.
    always_comb begin
        dut_out = 1'b0;
        case (gate_mode)
            1:       dut_out = 1'b0;
            2:       dut_out = 1'b1;
            default: dut_out = (in1_drv & in2_drv) | in3_drv;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"},
              {20'd0, in1_drv, in2_drv, in3_drv, busy, done, pass, err_count, fail_vector},
              32'd0);
    endtask

    // Pulse start, follow the run to its end and check results; restart_at re-pulses start mid-run.
    task automatic run_check(input string tag, input int restart_at,
                             input logic [3:0] exp_err, input logic [7:0] exp_fail);
        int cycles = 0;
        int drv_errs = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_first_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_cleared"}, {20'd0, err_count, fail_vector}, 32'd0);
        while (busy && cycles < 200) begin
            if ({in1_drv, in2_drv, in3_drv} != 3'(cycles / 5)) drv_errs++;
            start = (cycles == restart_at) ? 1'b1 : 1'b0;
            cycles++;
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_busy_cycles"}, 32'(cycles), 32'd40);
        check({tag, "_drv_seq"}, 32'(drv_errs), 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_pass"}, {31'd0, pass}, {31'd0, (exp_err == 4'd0)});
        check({tag, "_err"}, {28'd0, err_count}, {28'd0, exp_err});
        check({tag, "_fail"}, {24'd0, fail_vector}, {24'd0, exp_fail});
        repeat (3) @(negedge clk);
        check({tag, "_hold"}, {19'd0, busy, done, in1_drv, in2_drv, in3_drv, fail_vector},
              {19'd0, 1'b0, 1'b1, 3'b111, exp_fail});
    endtask

    initial begin
        int guard;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("idle");

        gate_mode = 0;
        run_check("good", -1, 4'd0, 8'h00);
        gate_mode = 1;
        run_check("stuck0", -1, 4'd5, 8'hEA);
        gate_mode = 2;
        run_check("stuck1", -1, 4'd3, 8'h15);

        // Reset in the middle of vector 4's settle window.
        gate_mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while ({in1_drv, in2_drv, in3_drv} != 3'b100 && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        check("reach_vec4", {31'd0, (guard < 100)}, 32'd1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        check_all_zero("rst_held");
        rst = 1'b0;
        run_check("after_rst", -1, 4'd0, 8'h00);

        // Start while busy is ignored; preceding stuck run proves results clear on restart from DONE.
        run_check("restart_busy", 10, 4'd0, 8'h00);
        gate_mode = 1;
        run_check("pre_clear", -1, 4'd5, 8'hEA);
        gate_mode = 0;
        run_check("rerun_done", -1, 4'd0, 8'h00);

        inject = 1'b1;
`ifdef AND_OR_FAULT_INJECT_EN
        run_check("inject", -1, 4'd8, 8'hFF);
`else
        run_check("inject_off", -1, 4'd0, 8'h00);
`endif
        inject = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
